// File: rtl/digitel_pkg.sv
// digitel_pkg: shared constants and types for the Digitel 2000 display scheduler.
//   NUM_DIGITS / DIG_W / IDX_W : display geometry (16 octal digits, 4-bit index)
//   ENABLE_RST                 : reset value of the per-digit enable mask
//   arb_state_t                : write-arbiter FSM states
//   grant_t                    : identity of the most recently granted requester
package digitel_pkg;
    localparam int NUM_DIGITS = 16;
    localparam int DIG_W      = 3;
    localparam int IDX_W      = 4;

    localparam logic [NUM_DIGITS-1:0] ENABLE_RST = 16'hFFFF;

    typedef enum logic {
        ARB_IDLE,
        ARB_ACK
    } arb_state_t;

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_t;
endpackage

// File: rtl/digitel_display_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin request/acknowledge arbiter.
//   clk, rst         : clock, synchronous active-high reset
//   req_a, req_b     : write requests (held until acknowledged)
//   grant_a, grant_b : combinational grant, asserted in the cycle the write commits
//   ack_a, ack_b     : registered one-cycle acknowledge, following the grant edge
// After every grant one ACK cycle ignores all requests, so the arbiter commits
// at most one write per two cycles.
module rr_arbiter2
    import digitel_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b,
    output logic ack_a,
    output logic ack_b
);
    arb_state_t state, state_next;
    grant_t     last_grant, last_grant_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_B;
            ack_a      <= '0;
            ack_b      <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            ack_a      <= grant_a;
            ack_b      <= grant_b;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        grant_a         = '0;
        grant_b         = '0;
        case (state)
            ARB_IDLE: begin
                if (req_a && req_b) begin
                    // Tie: favour whichever requester was not served last.
                    if (last_grant == GRANT_B) begin
                        grant_a = '1;
                    end else begin
                        grant_b = '1;
                    end
                end else begin
                    grant_a = req_a;
                    grant_b = req_b;
                end
                if (grant_a) begin
                    state_next      = ARB_ACK;
                    last_grant_next = GRANT_A;
                end else if (grant_b) begin
                    state_next      = ARB_ACK;
                    last_grant_next = GRANT_B;
                end
            end
            ARB_ACK: state_next = ARB_IDLE;
            default: state_next = ARB_IDLE;
        endcase
    end
endmodule

// File: rtl/digitel_display_scheduler.sv
// digitel_display_scheduler: frame buffer, scan timing and masking for the
// Digitel 2000 16x7-segment display.
//   CLK, RST                      : clock, synchronous active-high reset
//   wr_req/idx/dig/dp/ack_a       : sequencer write port (request/acknowledge)
//   wr_req/idx/dig/dp/ack_b       : UI write port (request/acknowledge)
//   cfg_we, cfg_enable, cfg_blink : load per-digit enable and blink masks
//   digits                        : packed octal digits, digit i at [3i+2:3i]
//   decimal_points                : per-digit decimal point
//   show_only_these               : effective visible-digit mask (registered)
//   refresh                       : toggles once per digit advance
//   frame_tick                    : one-cycle pulse when the scan wraps 15 -> 0
module digitel_display_scheduler
    import digitel_pkg::*;
#(
    parameter int REFRESH_DIV  = 65536,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        wr_req_a,
    input  logic [IDX_W-1:0]            wr_idx_a,
    input  logic [DIG_W-1:0]            wr_dig_a,
    input  logic                        wr_dp_a,
    output logic                        wr_ack_a,
    input  logic                        wr_req_b,
    input  logic [IDX_W-1:0]            wr_idx_b,
    input  logic [DIG_W-1:0]            wr_dig_b,
    input  logic                        wr_dp_b,
    output logic                        wr_ack_b,
    input  logic                        cfg_we,
    input  logic [NUM_DIGITS-1:0]       cfg_enable,
    input  logic [NUM_DIGITS-1:0]       cfg_blink,
    output logic [NUM_DIGITS*DIG_W-1:0] digits,
    output logic [NUM_DIGITS-1:0]       decimal_points,
    output logic [NUM_DIGITS-1:0]       show_only_these,
    output logic                        refresh,
    output logic                        frame_tick
);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]                      prescaler;
    logic [IDX_W-1:0]                      scan_idx;
    logic [FRM_W-1:0]                      frame_cnt;
    logic                                  blink_phase;
    logic [NUM_DIGITS-1:0]                 enable;
    logic [NUM_DIGITS-1:0]                 blink;
    logic [NUM_DIGITS-1:0][DIG_W-1:0]      digit_buf;

    logic                                  pre_wrap;
    logic                                  scan_wrap;
    logic                                  grant_a;
    logic                                  grant_b;
    logic                                  wr_en;
    logic [IDX_W-1:0]                      wr_idx;
    logic [DIG_W-1:0]                      wr_dig;
    logic                                  wr_dp;

    rr_arbiter2 u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req_a   (wr_req_a),
        .req_b   (wr_req_b),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .ack_a   (wr_ack_a),
        .ack_b   (wr_ack_b)
    );

    always_comb begin
        pre_wrap  = (prescaler == PRE_LAST);
        scan_wrap = pre_wrap && (scan_idx == '1);
        wr_en     = grant_a | grant_b;
        wr_idx    = grant_a ? wr_idx_a : wr_idx_b;
        wr_dig    = grant_a ? wr_dig_a : wr_dig_b;
        wr_dp     = grant_a ? wr_dp_a  : wr_dp_b;
    end

    // Scan timing: prescaler drives refresh and the scan index that mirrors
    // the display driver's own digit counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler  <= '0;
            refresh    <= '0;
            scan_idx   <= '0;
            frame_tick <= '0;
        end else begin
            frame_tick <= scan_wrap;
            if (pre_wrap) begin
                prescaler <= '0;
                refresh   <= ~refresh;
                scan_idx  <= scan_idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Blink phase advances on the registered frame_tick pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt   <= '0;
            blink_phase <= '0;
        end else if (frame_tick) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            enable          <= ENABLE_RST;
            blink           <= '0;
            show_only_these <= ENABLE_RST;
        end else begin
            if (cfg_we) begin
                enable <= cfg_enable;
                blink  <= cfg_blink;
            end
            show_only_these <= enable & ~(blink & {NUM_DIGITS{blink_phase}});
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            digit_buf      <= '0;
            decimal_points <= '0;
        end else if (wr_en) begin
            digit_buf[wr_idx]      <= wr_dig;
            decimal_points[wr_idx] <= wr_dp;
        end
    end

    assign digits = digit_buf;
endmodule

// File: tb/tb_digitel_display_scheduler.sv
module tb_digitel_display_scheduler;
    localparam int DIV     = 4;
    localparam int BF      = 2;
    localparam int FRAME   = 16 * DIV;
    localparam int BLINK_T = BF * FRAME;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wr_req_a = 1'b0, wr_dp_a = 1'b0, wr_ack_a;
    logic [3:0]  wr_idx_a = '0;
    logic [2:0]  wr_dig_a = '0;
    logic        wr_req_b = 1'b0, wr_dp_b = 1'b0, wr_ack_b;
    logic [3:0]  wr_idx_b = '0;
    logic [2:0]  wr_dig_b = '0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_enable = '0, cfg_blink = '0;
    logic [47:0] digits;
    logic [15:0] decimal_points, show_only_these;
    logic        refresh, frame_tick;

    int tests = 0;
    int fails = 0;
    int t = 0;   // posedges since reset release

    logic [2:0]  m_dig [16];
    logic [15:0] m_dp;

    digitel_display_scheduler #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
        .CLK(CLK), .RST(RST),
        .wr_req_a(wr_req_a), .wr_idx_a(wr_idx_a), .wr_dig_a(wr_dig_a), .wr_dp_a(wr_dp_a), .wr_ack_a(wr_ack_a),
        .wr_req_b(wr_req_b), .wr_idx_b(wr_idx_b), .wr_dig_b(wr_dig_b), .wr_dp_b(wr_dp_b), .wr_ack_b(wr_ack_b),
        .cfg_we(cfg_we), .cfg_enable(cfg_enable), .cfg_blink(cfg_blink),
        .digits(digits), .decimal_points(decimal_points), .show_only_these(show_only_these),
        .refresh(refresh), .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) t <= RST ? 0 : t + 1;

    function automatic logic [47:0] model_digits();
        logic [47:0] v = '0;
        for (int i = 0; i < 16; i++) v[3*i +: 3] = m_dig[i];
        return v;
    endfunction

    function automatic logic exp_refresh(int tt);
        return ((tt / DIV) % 2) == 1;
    endfunction

    function automatic logic exp_tick(int tt);
        return (tt > 0) && (tt % FRAME == 0);
    endfunction

    // Phase as seen on show_only_these: tick after edge 64k, phase flips on
    // the following edge for every BF-th tick, mask registered one edge later.
    function automatic logic exp_phase(int tt);
        if (tt < 2) return 1'b0;
        return (((tt - 2) / BLINK_T) % 2) == 1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) m_dig[i] = '0;
        m_dp = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1; wr_req_a = 1'b0; wr_req_b = 1'b0; cfg_we = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        RST = 1'b1; wr_req_a = 1'b0; wr_req_b = 1'b0; cfg_we = 1'b0;
        repeat (3) tick();
        clear_model();
        tests++; if (digits !== 48'h0) begin fails++; $display("FAIL reset_digits: got %h want 0", digits); end
        tests++; if (decimal_points !== 16'h0) begin fails++; $display("FAIL reset_dp: got %h want 0", decimal_points); end
        tests++; if (show_only_these !== 16'hFFFF) begin fails++; $display("FAIL reset_show: got %h want ffff", show_only_these); end
        tests++; if (refresh !== 1'b0) begin fails++; $display("FAIL reset_refresh: got %b want 0", refresh); end
        tests++; if ({wr_ack_a, wr_ack_b} !== 2'b00) begin fails++; $display("FAIL reset_acks: got %b want 00", {wr_ack_a, wr_ack_b}); end
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick); end
        RST = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            tests++; if (refresh !== exp_refresh(k)) begin fails++; $display("FAIL reset_refresh_cadence t=%0d: got %b want %b", k, refresh, exp_refresh(k)); end
            tests++; if (frame_tick !== exp_tick(k)) begin fails++; $display("FAIL reset_frame_cadence t=%0d: got %b want %b", k, frame_tick, exp_tick(k)); end
        end
    endtask

    task automatic test_single_write();
        wr_req_a = 1'b1; wr_idx_a = 4'd5; wr_dig_a = 3'o7; wr_dp_a = 1'b1;
        tick();
        m_dig[5] = 3'o7; m_dp[5] = 1'b1;
        tests++; if ({wr_ack_a, wr_ack_b} !== 2'b10) begin fails++; $display("FAIL single_ack: got %b want 10", {wr_ack_a, wr_ack_b}); end
        tests++; if (digits[17:15] !== 3'o7) begin fails++; $display("FAIL single_digit: got %o want 7", digits[17:15]); end
        tests++; if (decimal_points[5] !== 1'b1) begin fails++; $display("FAIL single_dp: got %b want 1", decimal_points[5]); end
        wr_req_a = 1'b0;
        tick();
        tests++; if (wr_ack_a !== 1'b0) begin fails++; $display("FAIL single_ack_width: got %b want 0", wr_ack_a); end
        tick();
        tests++; if (wr_ack_a !== 1'b0) begin fails++; $display("FAIL single_no_rewrite: got %b want 0", wr_ack_a); end
    endtask

    task automatic test_random_writes();
        for (int n = 0; n < 24; n++) begin
            logic        sel = 1'($urandom_range(0, 1));
            logic [3:0]  idx = 4'($urandom_range(0, 15));
            logic [2:0]  dg  = 3'($urandom_range(0, 7));
            logic        dp  = 1'($urandom_range(0, 1));
            if (sel) begin wr_req_b = 1'b1; wr_idx_b = idx; wr_dig_b = dg; wr_dp_b = dp; end
            else     begin wr_req_a = 1'b1; wr_idx_a = idx; wr_dig_a = dg; wr_dp_a = dp; end
            tick();
            m_dig[idx] = dg; m_dp[idx] = dp;
            tests++; if ({wr_ack_a, wr_ack_b} !== {~sel, sel}) begin fails++; $display("FAIL rand_ack n=%0d: got %b want %b", n, {wr_ack_a, wr_ack_b}, {~sel, sel}); end
            tests++; if (digits !== model_digits()) begin fails++; $display("FAIL rand_digits n=%0d: got %h want %h", n, digits, model_digits()); end
            tests++; if (decimal_points !== m_dp) begin fails++; $display("FAIL rand_dp n=%0d: got %h want %h", n, decimal_points, m_dp); end
            wr_req_a = 1'b0; wr_req_b = 1'b0;
            tick();
            tests++; if ({wr_ack_a, wr_ack_b} !== 2'b00) begin fails++; $display("FAIL rand_ack_clear n=%0d: got %b want 00", n, {wr_ack_a, wr_ack_b}); end
        end
    endtask

    task automatic test_contention();
        logic exp_a = 1'b1;
        do_reset();
        wr_req_a = 1'b1; wr_idx_a = 4'($urandom_range(0, 15)); wr_dig_a = 3'($urandom_range(0, 7)); wr_dp_a = 1'($urandom_range(0, 1));
        wr_req_b = 1'b1; wr_idx_b = 4'($urandom_range(0, 15)); wr_dig_b = 3'($urandom_range(0, 7)); wr_dp_b = 1'($urandom_range(0, 1));
        for (int g = 0; g < 8; g++) begin
            tick();
            if (exp_a) begin m_dig[wr_idx_a] = wr_dig_a; m_dp[wr_idx_a] = wr_dp_a; end
            else       begin m_dig[wr_idx_b] = wr_dig_b; m_dp[wr_idx_b] = wr_dp_b; end
            tests++; if ({wr_ack_a, wr_ack_b} !== {exp_a, ~exp_a}) begin fails++; $display("FAIL contend_ack g=%0d: got %b want %b", g, {wr_ack_a, wr_ack_b}, {exp_a, ~exp_a}); end
            tests++; if (digits !== model_digits() || decimal_points !== m_dp) begin fails++; $display("FAIL contend_buf g=%0d: got %h/%h want %h/%h", g, digits, decimal_points, model_digits(), m_dp); end
            if (exp_a) begin wr_idx_a = 4'($urandom_range(0, 15)); wr_dig_a = 3'($urandom_range(0, 7)); wr_dp_a = 1'($urandom_range(0, 1)); end
            else       begin wr_idx_b = 4'($urandom_range(0, 15)); wr_dig_b = 3'($urandom_range(0, 7)); wr_dp_b = 1'($urandom_range(0, 1)); end
            tick();
            tests++; if ({wr_ack_a, wr_ack_b} !== 2'b00) begin fails++; $display("FAIL contend_gap g=%0d: got %b want 00", g, {wr_ack_a, wr_ack_b}); end
            exp_a = ~exp_a;
        end
        wr_req_a = 1'b0; wr_req_b = 1'b0;
        tick();
    endtask

    task automatic test_blink();
        logic [15:0] old_en = 16'hFFFF, old_bl = 16'h0003;
        logic [15:0] new_en = 16'($urandom), new_bl = 16'($urandom);
        logic [15:0] exp_m;
        logic [2:0]  wd = 3'($urandom_range(1, 7));
        RST = 1'b1; wr_req_a = 1'b0; wr_req_b = 1'b0;
        repeat (3) tick();
        clear_model();
        RST = 1'b0; cfg_we = 1'b1; cfg_enable = old_en; cfg_blink = old_bl;
        tick();
        cfg_we = 1'b0;
        while (t < 400) begin
            if (t == 300) begin
                cfg_we = 1'b1; cfg_enable = new_en; cfg_blink = new_bl;
                wr_req_b = 1'b1; wr_idx_b = 4'd12; wr_dig_b = wd; wr_dp_b = 1'b1;
            end
            tick();
            cfg_we = 1'b0;
            if (t == 301) begin
                wr_req_b = 1'b0;
                m_dig[12] = wd; m_dp[12] = 1'b1;
                tests++; if (wr_ack_b !== 1'b1) begin fails++; $display("FAIL blink_cfg_write_ack: got %b want 1", wr_ack_b); end
                tests++; if (digits !== model_digits() || decimal_points !== m_dp) begin fails++; $display("FAIL blink_cfg_write_buf: got %h/%h want %h/%h", digits, decimal_points, model_digits(), m_dp); end
            end
            if (t >= 302) exp_m = new_en & ~(new_bl & {16{exp_phase(t)}});
            else          exp_m = old_en & ~(old_bl & {16{exp_phase(t)}});
            tests++; if (show_only_these !== exp_m) begin fails++; $display("FAIL blink_mask t=%0d: got %h want %h", t, show_only_these, exp_m); end
            tests++; if (frame_tick !== exp_tick(t) || refresh !== exp_refresh(t)) begin fails++; $display("FAIL blink_timing t=%0d: got %b%b want %b%b", t, frame_tick, refresh, exp_tick(t), exp_refresh(t)); end
        end
    endtask

    task automatic test_reset_mid_ack();
        wr_req_a = 1'b1; wr_idx_a = 4'd9; wr_dig_a = 3'o5; wr_dp_a = 1'b1;
        tick();
        tests++; if (wr_ack_a !== 1'b1 || digits[29:27] !== 3'o5) begin fails++; $display("FAIL midack_pre: got %b/%o want 1/5", wr_ack_a, digits[29:27]); end
        RST = 1'b1; wr_req_a = 1'b0;
        tick();
        clear_model();
        tests++; if (wr_ack_a !== 1'b0) begin fails++; $display("FAIL midack_ack: got %b want 0", wr_ack_a); end
        tests++; if (digits !== 48'h0 || decimal_points !== 16'h0) begin fails++; $display("FAIL midack_buf: got %h/%h want 0/0", digits, decimal_points); end
        tick();
        RST = 1'b0;
        wr_req_a = 1'b1; wr_idx_a = 4'd3; wr_dig_a = 3'o6; wr_dp_a = 1'b0;
        wr_req_b = 1'b1; wr_idx_b = 4'd4; wr_dig_b = 3'o2; wr_dp_b = 1'b1;
        tick();
        m_dig[3] = 3'o6;
        tests++; if ({wr_ack_a, wr_ack_b} !== 2'b10) begin fails++; $display("FAIL midack_tie: got %b want 10", {wr_ack_a, wr_ack_b}); end
        tests++; if (digits !== model_digits()) begin fails++; $display("FAIL midack_tie_buf: got %h want %h", digits, model_digits()); end
        wr_req_a = 1'b0; wr_req_b = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] d1 = 3'($urandom_range(1, 7));
        logic [2:0] d2 = 3'($urandom_range(1, 7));
        logic       p2 = 1'($urandom_range(0, 1));
        do_reset();
        while (t < 140) begin
            if (t == 10) begin wr_req_a = 1'b1; wr_idx_a = 4'd15; wr_dig_a = d1; wr_dp_a = 1'b1; end
            if (t == 11) begin wr_idx_a = 4'd0; wr_dig_a = d2; wr_dp_a = p2; end
            if (t == 13) wr_req_a = 1'b0;
            tick();
            if (t == 11) begin
                tests++; if (wr_ack_a !== 1'b1 || digits[47:45] !== d1 || decimal_points[15] !== 1'b1) begin fails++; $display("FAIL b2b_first: got %b/%o/%b want 1/%o/1", wr_ack_a, digits[47:45], decimal_points[15], d1); end
            end
            if (t == 12) begin
                tests++; if (wr_ack_a !== 1'b0) begin fails++; $display("FAIL b2b_gap: got %b want 0", wr_ack_a); end
            end
            if (t == 13) begin
                tests++; if (wr_ack_a !== 1'b1 || digits[2:0] !== d2 || decimal_points[0] !== p2 || digits[47:45] !== d1) begin fails++; $display("FAIL b2b_second: got %b/%o/%b/%o want 1/%o/%b/%o", wr_ack_a, digits[2:0], decimal_points[0], digits[47:45], d2, p2, d1); end
            end
            tests++; if (frame_tick !== exp_tick(t) || refresh !== exp_refresh(t)) begin fails++; $display("FAIL b2b_timing t=%0d: got %b%b want %b%b", t, frame_tick, refresh, exp_tick(t), exp_refresh(t)); end
        end
    endtask

    initial begin
        clear_model();
        @(negedge CLK);
        test_reset();
        test_single_write();
        test_random_writes();
        test_contention();
        test_blink();
        test_reset_mid_ack();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/digitel_display_scheduler.md
# digitel_display_scheduler

Owns the 16-digit octal frame buffer for the Digitel 2000 16×7-segment display and schedules its scan.
- Two write requesters share the buffer through a round-robin, request/acknowledge arbiter: requester A is the sequencer, requester B is the UI.
- Generates the digit-advance `refresh` toggle from a programmable prescaler.
- Applies per-digit enable and blink masking.
- Outputs feed the 16-digit display driver directly: the digits, `decimal_points`, `show_only_these` and `refresh`.

## Interface
Parameters:
- `REFRESH_DIV`, default 65536: CLK cycles per `refresh` toggle, i.e. per digit advance. Legal range ≥ 2.
- `BLINK_FRAMES`, default 64: full 16-digit scans per blink half-period. Legal range ≥ 1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `CLK` in 1: system clock.
  - `RST` in 1: synchronous, active-high reset.
- Requester A (sequencer):
  - `wr_req_a` in 1: write request.
  - `wr_idx_a` in 4: target digit index.
  - `wr_dig_a` in 3: octal value.
  - `wr_dp_a` in 1: decimal point.
  - `wr_ack_a` out 1: one-cycle acknowledge.
- Requester B (UI):
  - `wr_req_b`, `wr_idx_b`, `wr_dig_b`, `wr_dp_b`, `wr_ack_b`: same meanings as the A ports.
- Configuration:
  - `cfg_we` in 1: load both masks this cycle.
  - `cfg_enable` in 16: per-digit enable mask.
  - `cfg_blink` in 16: per-digit blink mask.
- To the display driver:
  - `digits` out 48: packed octal digits; digit i is at [3i+2:3i].
  - `decimal_points` out 16: per-digit decimal point.
  - `show_only_these` out 16: effective visible-digit mask.
  - `refresh` out 1: toggles once per digit advance.
- Status:
  - `frame_tick` out 1: one-cycle pulse when the scan wraps from digit 15 to digit 0.

## Operation
- **Prescaler:** counter counts 0..`REFRESH_DIV`-1.
  - At terminal count it wraps to 0, `refresh` toggles, and the internal scan index (4 bits) increments.
  - The scan index mirrors the driver's digit counter; the driver's counter also starts at 0.
- **Frame tick:** when the scan index wraps 15→0, `frame_tick` pulses for one cycle, registered together with the wrap.
- **Blink:** the frame counter counts `frame_tick`s 0..`BLINK_FRAMES`-1; on wrap `blink_phase` toggles.
  - `show_only_these` = `enable` & ~(`blink` & {16{`blink_phase`}}), registered.
- **Configuration:** `cfg_we` loads `enable` and `blink` at the edge. Masks take effect on `show_only_these` one cycle later.
- **Arbiter FSM** (states `ARB_IDLE`, `ARB_ACK`):
  - `ARB_IDLE`, no request: stay in `ARB_IDLE`.
  - `ARB_IDLE`, one request: write that requester's idx/dig/dp into the buffer, set its ack, go to `ARB_ACK`.
  - `ARB_IDLE`, both requesting: grant the requester not granted last (round-robin). `last_grant` resets to B, so A wins the first tie.
  - `ARB_ACK`: clear the ack, ignore all requests, return to `ARB_IDLE`.
- **Handshake:**
  - A requester holds req and its data stable until it sees its ack.
  - It may drop req or reassert it for a new write on the edge ending the ack cycle.
  - A req still high in `ARB_IDLE` after its ack is a new write.
  - At most one write per 2 cycles in total.
  - A starved requester waits at most 2 writes (4 cycles) once the other has been served.
- **Reset values:**
  - `digits`=0, `decimal_points`=0, `enable`=16'hFFFF, `blink`=0, so `show_only_these`=16'hFFFF.
  - `refresh`=0, scan index=0, prescaler=0, frame counter=0, `blink_phase`=0.
  - Both acks=0, `frame_tick`=0, state=`ARB_IDLE`, `last_grant`=B.
- **Reset mid-transfer:** an asserted ack drops on the reset edge. A buffer write committed before reset is cleared by reset.

## Timing
- **Write latency:** req seen at edge e0 → buffer and ack updated at e0. New `digits` value is visible in the cycle after e0, the same cycle as ack.
- **Refresh:** first `refresh` toggle occurs `REFRESH_DIV` cycles after reset release. Period thereafter is 2·`REFRESH_DIV`.
- **Frame:** `frame_tick` every 16·`REFRESH_DIV` cycles, coincident with the 16th `refresh` toggle.
- **Blink:** `blink_phase` toggles every `BLINK_FRAMES`·16·`REFRESH_DIV` cycles.
- **Simultaneous events:**
  - `cfg_we` and a buffer write in the same cycle are independent; both take effect.
  - The same digit written twice in consecutive grants ends with the later value.
- **Widths:** prescaler width is `$clog2(REFRESH_DIV)`; frame counter width is `$clog2(BLINK_FRAMES)`, minimum 1.
  - The digit index is 4 bits; all 16 values are valid, so there is no out-of-range case.

## Structure
- **Package `digitel_pkg`:**
  - `NUM_DIGITS`=16, `DIG_W`=3, `IDX_W`=4.
  - Arbiter state enum `ARB_IDLE`/`ARB_ACK`.
  - Reset constant `ENABLE_RST`=16'hFFFF.
- **Sub-module `rr_arbiter2`:** two-way round-robin with `last_grant` and the 2-state ack FSM.
  - Inputs: reqs. Outputs: grant_a, grant_b, ack pulses.
  - The top holds the prescaler, scan/frame/blink counters, the frame buffer and mask logic.

## Test plan
Bench uses `REFRESH_DIV`=4, `BLINK_FRAMES`=2.
- **Reset state:** assert `RST` 3 cycles → `digits`=0, `show_only_these`=16'hFFFF, `refresh`=0, acks=0. After release, first `refresh` toggle occurs 4 cycles later; `frame_tick` follows 64 cycles after reset release.
- **Single write:** A writes idx=5, dig=3'o7, dp=1 → `wr_ack_a` high exactly 1 cycle; `digits`[17:15]=7 and `decimal_points`[5]=1 in that cycle.
- **Contention:** A and B held high continuously → grants alternate A, B, A, B at 2-cycle spacing; each ack is 1 cycle and acks never overlap.
- **Blink:** `cfg_we` with enable=16'hFFFF, blink=16'h0003 → `show_only_these` alternates 16'hFFFF / 16'hFFFC, toggling every 128 cycles.
- **Reset mid-ack:** assert `RST` in A's ack cycle → `wr_ack_a`=0 and `digits`=0 on the next cycle; `last_grant`=B, so a subsequent A+B tie grants A.
- **Back-to-back writes:** A writes idx 15 then idx 0 → both values land; `frame_tick` cadence is unaffected by writes.
